// File: rtl/program_loader.sv
// program_loader: boot-time instruction-memory writer; assembles big-endian 16-bit words from a byte stream (PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte).
// Latency: io_instrWrite pulses for one cycle, one cycle after the low-byte transfer.
// Backpressure: io_rxReady is high in every loading state and low in DONE/ERROR until io_start.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            io_rxData,
  input  logic                  io_rxValid,
  output logic                  io_rxReady,
  input  logic                  io_start,
  output logic [ADDR_WIDTH-1:0] io_addr,
  output logic [DATA_WIDTH-1:0] io_instrIn,
  output logic                  io_instrWrite,
  output logic                  io_cpuReset,
  output logic                  io_done,
  output logic                  io_error
);

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_WORD_HI,
    ST_WORD_LO,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERROR
  } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t ST_IMAGE_END = ST_CHECK;
`else
  localparam state_t ST_IMAGE_END = ST_DONE;
`endif

  // Largest legal word count; 17 bits so a 16-bit count can be compared against it.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  state_t                state_q;
  state_t                state_d;
  logic                  rx_fire;
  logic                  restart;
  logic [7:0]            len_hi_q;
  logic [7:0]            data_hi_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [16:0]           full_count;
  logic                  last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  assign rx_fire    = io_rxValid && io_rxReady;
  assign restart    = io_start && (state_q == ST_DONE || state_q == ST_ERROR);
  assign full_count = {1'b0, len_hi_q, io_rxData};
  assign last_word  = (words_q + 1'b1) == count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LEN_HI:  if (rx_fire) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (rx_fire) begin
          if (full_count == '0)        state_d = ST_IMAGE_END;
          else if (full_count > DEPTH) state_d = ST_ERROR;
          else                         state_d = ST_WORD_HI;
        end
      end
      ST_WORD_HI: if (rx_fire) state_d = ST_WORD_LO;
      ST_WORD_LO: if (rx_fire) state_d = last_word ? ST_IMAGE_END : ST_WORD_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK:   if (rx_fire) state_d = (io_rxData == csum_q) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE:    if (io_start) state_d = ST_LEN_HI;
      ST_ERROR:   if (io_start) state_d = ST_LEN_HI;
      default:    state_d = ST_LEN_HI;
    endcase
  end

  always_comb begin
    io_rxReady  = 1'b1;
    io_done     = 1'b0;
    io_error    = 1'b0;
    io_cpuReset = 1'b1;
    case (state_q)
      ST_DONE: begin
        io_rxReady  = 1'b0;
        io_done     = 1'b1;
        io_cpuReset = 1'b0;
      end
      ST_ERROR: begin
        io_rxReady = 1'b0;
        io_error   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: the write port registers hold between strobes; only the pointer/counter restart.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_hi_q      <= '0;
      data_hi_q     <= '0;
      count_q       <= '0;
      words_q       <= '0;
      ptr_q         <= '0;
      io_addr       <= '0;
      io_instrIn    <= '0;
      io_instrWrite <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      io_instrWrite <= 1'b0;
      if (restart) begin
        words_q <= '0;
        ptr_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_q  <= '0;
`endif
      end
      if (rx_fire) begin
        case (state_q)
          ST_LEN_HI:  len_hi_q  <= io_rxData;
          ST_LEN_LO:  count_q   <= full_count[ADDR_WIDTH:0];
          ST_WORD_HI: data_hi_q <= io_rxData;
          ST_WORD_LO: begin
            io_instrIn    <= DATA_WIDTH'({data_hi_q, io_rxData});
            io_addr       <= ptr_q;
            io_instrWrite <= 1'b1;
            ptr_q         <= ptr_q + 1'b1;
            words_q       <= words_q + 1'b1;
          end
          default: ;
        endcase
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (state_q != ST_CHECK) csum_q <= csum_q ^ io_rxData;
`endif
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random and directed images checked against an image-format reference model.
module tb_program_loader;

  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    io_rxData;
  logic          io_rxValid;
  logic          io_rxReady;
  logic          io_start;
  logic [AW-1:0] io_addr;
  logic [15:0]   io_instrIn;
  logic          io_instrWrite;
  logic          io_cpuReset;
  logic          io_done;
  logic          io_error;

  int checks = 0;
  int errors = 0;
  int nwrites;
  logic [7:0]    img[$];
  logic [AW-1:0] last_addr;
  logic [15:0]   last_data;

  program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .io_rxData(io_rxData), .io_rxValid(io_rxValid), .io_rxReady(io_rxReady),
    .io_start(io_start), .io_addr(io_addr), .io_instrIn(io_instrIn),
    .io_instrWrite(io_instrWrite), .io_cpuReset(io_cpuReset),
    .io_done(io_done), .io_error(io_error)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; io_rxValid = 1'b0; io_start = 1'b0; io_rxData = 8'h00;
    step(); step();
    reset = 1'b0;
    last_addr = '0; last_data = '0;
  endtask

  task automatic pulse_start();
    io_start = 1'b1; step(); io_start = 1'b0;
  endtask

  task automatic build_image(input int n);
    img.delete();
    img.push_back(8'(n >> 8)); img.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) img.push_back(8'($urandom));
  endtask

  task automatic build_basic();
    img = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
  endtask

  task automatic append_csum(input bit good);
    logic [7:0] x = 8'h00;
    foreach (img[i]) x ^= img[i];
    img.push_back(good ? x : ~x);
  endtask

  // Drives img byte by byte; expected strobes follow purely from the image format.
  task automatic send_stream(input bit gaps);
    int  n;
    bit  lo;
    logic [AW-1:0] ea;
    logic [15:0]   ed;
    nwrites = 0;
    n = (img.size() >= 2) ? int'({img[0], img[1]}) : 0;
    for (int k = 0; k < img.size(); k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          io_rxValid = 1'b0; io_rxData = 8'($urandom);
          step();
          checks++;
          if (io_instrWrite !== 1'b0 || io_addr !== last_addr || io_instrIn !== last_data) begin
            errors++;
            $display("FAIL gap_hold: wr=%b addr=%h data=%h, required wr=0 addr=%h data=%h",
                     io_instrWrite, io_addr, io_instrIn, last_addr, last_data);
          end
        end
      end
      io_rxValid = 1'b1; io_rxData = img[k];
      checks++;
      if (io_rxReady !== 1'b1) begin
        errors++; $display("FAIL rx_ready byte %0d: got %b required 1", k, io_rxReady);
      end
      step();
      lo = (k >= 2) && (k < 2 + 2 * n) && ((k - 2) % 2 == 1);
      checks++;
      if (io_instrWrite !== lo) begin
        errors++; $display("FAIL strobe byte %0d: got %b required %b", k, io_instrWrite, lo);
      end
      if (lo) begin
        ea = AW'((k - 2) / 2);
        ed = {img[k-1], img[k]};
        checks++;
        if (io_addr !== ea || io_instrIn !== ed) begin
          errors++;
          $display("FAIL write word %0d: got addr=%h data=%h required addr=%h data=%h",
                   (k - 2) / 2, io_addr, io_instrIn, ea, ed);
        end
        last_addr = ea; last_data = ed; nwrites++;
      end
    end
    io_rxValid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({io_rxReady, io_instrWrite, io_cpuReset, io_done, io_error, io_addr, io_instrIn}
        !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b wr=%b cpurst=%b done=%b err=%b addr=%h data=%h, required 1 0 1 0 0 00 0000",
               io_rxReady, io_instrWrite, io_cpuReset, io_done, io_error, io_addr, io_instrIn);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    build_basic();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    append_csum(1'b1);
`endif
    send_stream(1'b0);
    checks++;
    if (nwrites != 3 || {io_done, io_cpuReset, io_error, io_rxReady} !== 4'b1000) begin
      errors++;
      $display("FAIL basic_done: writes=%0d done=%b cpurst=%b err=%b rdy=%b, required 3 1 0 0 0",
               nwrites, io_done, io_cpuReset, io_error, io_rxReady);
    end
    io_rxValid = 1'b1; io_rxData = 8'h55;
    repeat (3) begin
      step();
      checks++;
      if (io_instrWrite !== 1'b0 || io_done !== 1'b1 || io_rxReady !== 1'b0) begin
        errors++;
        $display("FAIL done_ignores_bytes: wr=%b done=%b rdy=%b, required 0 1 0", io_instrWrite, io_done, io_rxReady);
      end
    end
    io_rxValid = 1'b0;
  endtask

  task automatic test_zero_count();
    apply_reset();
    img = '{8'h00, 8'h00};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    append_csum(1'b1);
`endif
    send_stream(1'b0);
    checks++;
    if (nwrites != 0 || io_done !== 1'b1 || io_cpuReset !== 1'b0) begin
      errors++;
      $display("FAIL zero_count: writes=%0d done=%b cpurst=%b, required 0 1 0", nwrites, io_done, io_cpuReset);
    end
  endtask

  task automatic test_oversize();
    apply_reset();
    img = '{8'h01, 8'h01};
    send_stream(1'b0);
    checks++;
    if (nwrites != 0 || {io_error, io_rxReady, io_cpuReset, io_done} !== 4'b1010) begin
      errors++;
      $display("FAIL oversize_error: writes=%0d err=%b rdy=%b cpurst=%b done=%b, required 0 1 0 1 0",
               nwrites, io_error, io_rxReady, io_cpuReset, io_done);
    end
    io_rxValid = 1'b1; io_rxData = 8'hAA;
    repeat (3) begin
      step();
      checks++;
      if (io_instrWrite !== 1'b0 || io_error !== 1'b1) begin
        errors++; $display("FAIL error_holds: wr=%b err=%b, required 0 1", io_instrWrite, io_error);
      end
    end
    io_rxValid = 1'b0;
    pulse_start();
    checks++;
    if ({io_error, io_rxReady, io_cpuReset, io_done} !== 4'b0110) begin
      errors++;
      $display("FAIL error_restart: err=%b rdy=%b cpurst=%b done=%b, required 0 1 1 0",
               io_error, io_rxReady, io_cpuReset, io_done);
    end
    build_basic();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    append_csum(1'b1);
`endif
    send_stream(1'b0);
    checks++;
    if (nwrites != 3 || io_done !== 1'b1) begin
      errors++; $display("FAIL reload_after_error: writes=%0d done=%b, required 3 1", nwrites, io_done);
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    build_basic();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    append_csum(1'b1);
`endif
    send_stream(1'b1);
    checks++;
    if (nwrites != 3 || io_done !== 1'b1 || io_cpuReset !== 1'b0) begin
      errors++;
      $display("FAIL gaps_done: writes=%0d done=%b cpurst=%b, required 3 1 0", nwrites, io_done, io_cpuReset);
    end
  endtask

  task automatic test_random_images();
    int n;
    apply_reset();
    for (int it = 0; it < 6; it++) begin
      if (it != 0) begin
        pulse_start();
        checks++;
        if (io_done !== 1'b0 || io_cpuReset !== 1'b1) begin
          errors++; $display("FAIL done_restart: done=%b cpurst=%b, required 0 1", io_done, io_cpuReset);
        end
      end
      n = $urandom_range(1, 12);
      build_image(n);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      append_csum(1'b1);
`endif
      send_stream(1'b1);
      checks++;
      if (nwrites != n || io_done !== 1'b1) begin
        errors++; $display("FAIL random_image %0d: writes=%0d done=%b, required %0d 1", it, nwrites, io_done, n);
      end
    end
  endtask

  task automatic test_full_depth();
    apply_reset();
    build_image(1 << AW);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    append_csum(1'b1);
`endif
    send_stream(1'b0);
    checks++;
    if (nwrites != (1 << AW) || io_done !== 1'b1 || io_error !== 1'b0) begin
      errors++;
      $display("FAIL full_depth: writes=%0d done=%b err=%b, required %0d 1 0", nwrites, io_done, io_error, 1 << AW);
    end
  endtask

  task automatic test_reset_midload();
    apply_reset();
    img = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB};
    send_stream(1'b0);
    reset = 1'b1;
    step();
    checks++;
    if ({io_rxReady, io_instrWrite, io_cpuReset, io_done, io_error, io_addr, io_instrIn}
        !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000}) begin
      errors++;
      $display("FAIL midload_reset: rdy=%b wr=%b cpurst=%b done=%b err=%b addr=%h data=%h, required 1 0 1 0 0 00 0000",
               io_rxReady, io_instrWrite, io_cpuReset, io_done, io_error, io_addr, io_instrIn);
    end
    reset = 1'b0;
    last_addr = '0; last_data = '0;
    build_image(4);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    append_csum(1'b1);
`endif
    send_stream(1'b1);
    checks++;
    if (nwrites != 4 || io_done !== 1'b1) begin
      errors++; $display("FAIL reload_after_reset: writes=%0d done=%b, required 4 1", nwrites, io_done);
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    apply_reset();
    build_basic();
    append_csum(1'b0);
    send_stream(1'b0);
    checks++;
    if (nwrites != 3 || {io_error, io_cpuReset, io_done} !== 3'b110) begin
      errors++;
      $display("FAIL bad_checksum: writes=%0d err=%b cpurst=%b done=%b, required 3 1 1 0",
               nwrites, io_error, io_cpuReset, io_done);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; io_rxValid = 1'b0; io_start = 1'b0; io_rxData = 8'h00;
    test_reset();
    test_basic();
    test_zero_count();
    test_oversize();
    test_gaps();
    test_random_images();
    test_full_depth();
    test_reset_midload();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
